// File: rtl/memoria_sync_if.sv
// memoria_sync_if: request/response bundle between the load/store unit and memoria_sync.
//   master : drives req, we, addr, wdata; receives ready, rvalid, rdata, addr_err, par_err
//   slave  : the memory side (receives requests, returns status and read data)
interface memoria_sync_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              addr_err;
    logic              par_err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata, addr_err, par_err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata, addr_err, par_err
    );
endinterface

// File: rtl/memoria_sync.sv
// memoria_sync: single-clock, single-port word memory for the data/stack space.
//   clk, rst : posedge clock, asynchronous active-high reset
//   bus      : memoria_sync_if.slave
//     req/we/addr/wdata : one request per cycle, accepted while ready=1
//     ready             : high in IDLE (low during post-reset clear and while rst high)
//     rvalid/rdata      : read data registered one cycle after the accepting edge, rdata held
//     addr_err          : pulse one cycle after a request with addr >= DEPTH
//     par_err           : pulse with rvalid on stored-parity mismatch
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word;
// without it par_err is constant 0.
module memoria_sync #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DEPTH          = 128,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic           clk,
    input logic           rst,
    memoria_sync_if.slave bus
);
    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_PARITY_EN
    logic              mem_par [DEPTH];
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              addr_err_q, addr_err_d;
    logic              par_err_q, par_err_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = {1'b0, bus.addr} < DEPTH_X;
    assign idx      = bus.addr[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        addr_err_d = 1'b0;
        par_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = idx;
        mem_wdata  = bus.wdata;

        case (state_q)
            S_CLEAR: begin
                // Requests are ignored here; the requester holds until ready.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.req) begin
                    addr_err_d = !in_range;
                    if (bus.we) begin
                        mem_we = in_range;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = in_range ? mem[idx] : '0;
`ifdef MEM_PARITY_EN
                        par_err_d = in_range && ((^mem[idx]) != mem_par[idx]);
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
            par_err_q  <= par_err_d;
        end
    end

    // Storage has no reset; zeroing is done by the CLEAR walk instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
`ifdef MEM_PARITY_EN
            mem_par[mem_waddr] <= ^mem_wdata;
`endif
        end
    end

    assign bus.ready    = (state_q == S_IDLE) && !rst;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.addr_err = addr_err_q;
    assign bus.par_err  = par_err_q;
endmodule

// File: tb/tb_memoria_sync.sv
module tb_memoria_sync;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 128;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    memoria_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    memoria_sync #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request for exactly one edge; outputs are sampled 1 time unit later.
    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus_if.req   = 1'b1;
        bus_if.we    = w;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(posedge clk);
        #1;
        bus_if.req = 1'b0;
        bus_if.we  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        @(posedge clk);
        #1;
        total++; if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", bus_if.ready); end
        total++; if (bus_if.rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0h exp=0", bus_if.rvalid); end
        total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", bus_if.rdata); end
        total++; if (bus_if.addr_err !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%0h exp=0", bus_if.addr_err); end
        total++; if (bus_if.par_err !== 1'b0) begin bad++; $display("FAIL rst_par_err got=%0h exp=0", bus_if.par_err); end
        rst = 1'b0;
        repeat (DEPTH - 1) @(posedge clk);
        #1;
        total++; if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL clear_ready_127 got=%0h exp=0", bus_if.ready); end
        @(posedge clk);
        #1;
        total++; if (bus_if.ready !== 1'b1) begin bad++; $display("FAIL clear_ready_128 got=%0h exp=1", bus_if.ready); end
        do_req(1'b0, 10'd5, '0);
        total++; if (bus_if.rvalid !== 1'b1) begin bad++; $display("FAIL rd5_rvalid got=%0h exp=1", bus_if.rvalid); end
        total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL rd5_rdata got=%0h exp=0", bus_if.rdata); end
        total++; if (bus_if.addr_err !== 1'b0) begin bad++; $display("FAIL rd5_addr_err got=%0h exp=0", bus_if.addr_err); end
        @(posedge clk);
        #1;
        total++; if (bus_if.rvalid !== 1'b0) begin bad++; $display("FAIL rd5_rvalid_pulse got=%0h exp=0", bus_if.rvalid); end
    endtask

    task automatic test_write_read();
        do_req(1'b1, 10'd10, 32'hDEAD_BEEF);
        total++; if (bus_if.rvalid !== 1'b0) begin bad++; $display("FAIL wr10_rvalid got=%0h exp=0", bus_if.rvalid); end
        do_req(1'b0, 10'd10, '0);
        total++; if (bus_if.rvalid !== 1'b1) begin bad++; $display("FAIL rd10_rvalid got=%0h exp=1", bus_if.rvalid); end
        total++; if (bus_if.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd10_rdata got=%0h exp=deadbeef", bus_if.rdata); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus_if.rvalid !== 1'b0) begin bad++; $display("FAIL rd10_rvalid_low got=%0h exp=0", bus_if.rvalid); end
        total++; if (bus_if.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd10_rdata_held got=%0h exp=deadbeef", bus_if.rdata); end
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 10'd11, 32'hA5A5_0001);
        do_req(1'b0, 10'd11, '0);
        total++; if (bus_if.rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL b2b_rdata got=%0h exp=a5a50001", bus_if.rdata); end
        do_req(1'b1, 10'd127, 32'h0000_0127);
        do_req(1'b1, 10'd0, 32'h0000_0F00);
        do_req(1'b0, 10'd127, '0);
        total++; if (bus_if.rdata !== 32'h0000_0127) begin bad++; $display("FAIL b2b_rd127 got=%0h exp=127", bus_if.rdata); end
        do_req(1'b0, 10'd0, '0);
        total++; if (bus_if.rdata !== 32'h0000_0F00) begin bad++; $display("FAIL b2b_rd0 got=%0h exp=f00", bus_if.rdata); end
        total++; if (bus_if.rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid got=%0h exp=1", bus_if.rvalid); end
    endtask

    task automatic test_addr_err();
        do_req(1'b0, 10'd200, '0);
        total++; if (bus_if.rvalid !== 1'b1) begin bad++; $display("FAIL rd200_rvalid got=%0h exp=1", bus_if.rvalid); end
        total++; if (bus_if.addr_err !== 1'b1) begin bad++; $display("FAIL rd200_addr_err got=%0h exp=1", bus_if.addr_err); end
        total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL rd200_rdata got=%0h exp=0", bus_if.rdata); end
        do_req(1'b1, 10'd128, 32'hFFFF_FFFF);
        total++; if (bus_if.addr_err !== 1'b1) begin bad++; $display("FAIL wr128_addr_err got=%0h exp=1", bus_if.addr_err); end
        total++; if (bus_if.rvalid !== 1'b0) begin bad++; $display("FAIL wr128_rvalid got=%0h exp=0", bus_if.rvalid); end
        do_req(1'b0, 10'd127, '0);
        total++; if (bus_if.rdata !== 32'h0000_0127) begin bad++; $display("FAIL rd127_after got=%0h exp=127", bus_if.rdata); end
        total++; if (bus_if.addr_err !== 1'b0) begin bad++; $display("FAIL rd127_addr_err got=%0h exp=0", bus_if.addr_err); end
        // 128 and 138 alias words 0 and 10 if the address were truncated.
        do_req(1'b0, 10'd0, '0);
        total++; if (bus_if.rdata !== 32'h0000_0F00) begin bad++; $display("FAIL rd0_no_alias got=%0h exp=f00", bus_if.rdata); end
        do_req(1'b0, 10'd138, '0);
        total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL rd138_rdata got=%0h exp=0", bus_if.rdata); end
        do_req(1'b0, 10'd1023, '0);
        total++; if (bus_if.addr_err !== 1'b1) begin bad++; $display("FAIL rd1023_addr_err got=%0h exp=1", bus_if.addr_err); end
        @(posedge clk);
        #1;
        total++; if (bus_if.addr_err !== 1'b0) begin bad++; $display("FAIL addr_err_pulse got=%0h exp=0", bus_if.addr_err); end
    endtask

    task automatic test_reset_mid_clear();
        do_req(1'b0, 10'd10, '0);
        total++; if (bus_if.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pre_rst_rdata got=%0h exp=deadbeef", bus_if.rdata); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL async_rst_rdata got=%0h exp=0", bus_if.rdata); end
        total++; if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL async_rst_ready got=%0h exp=0", bus_if.ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0h exp=0", bus_if.ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (DEPTH - 1) @(posedge clk);
        #1;
        total++; if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL mid_ready_127 got=%0h exp=0", bus_if.ready); end
        @(posedge clk);
        #1;
        total++; if (bus_if.ready !== 1'b1) begin bad++; $display("FAIL mid_ready_128 got=%0h exp=1", bus_if.ready); end
        do_req(1'b0, 10'd10, '0);
        total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL rd10_cleared got=%0h exp=0", bus_if.rdata); end
    endtask

    task automatic test_req_during_clear();
        int unsigned waited;
        logic        seen_out;
        do_req(1'b1, 10'd3, 32'h0000_5555);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 10'd3; bus_if.wdata = 32'h0000_1234;
        seen_out = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus_if.rvalid || bus_if.addr_err) seen_out = 1'b1;
        end
        bus_if.req = 1'b0; bus_if.we = 1'b0;
        total++; if (seen_out !== 1'b0) begin bad++; $display("FAIL clear_req_outputs got=%0h exp=0", seen_out); end
        waited = 0;
        while (!bus_if.ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        total++; if (bus_if.ready !== 1'b1) begin bad++; $display("FAIL clear_wait_ready got=%0h exp=1", bus_if.ready); end
        do_req(1'b0, 10'd3, '0);
        total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL rd3_after_clear got=%0h exp=0", bus_if.rdata); end
    endtask

    task automatic test_parity();
        do_req(1'b1, 10'd4, 32'h0000_0007);
        do_req(1'b0, 10'd4, '0);
        total++; if (bus_if.rdata !== 32'h7) begin bad++; $display("FAIL rd4_rdata got=%0h exp=7", bus_if.rdata); end
        total++; if (bus_if.par_err !== 1'b0) begin bad++; $display("FAIL rd4_par_err got=%0h exp=0", bus_if.par_err); end
        do_req(1'b1, 10'd3, 32'h0000_0001);
`ifdef MEM_PARITY_EN
        dut.mem_par[3] = ~dut.mem_par[3];
        do_req(1'b0, 10'd3, '0);
        total++; if (bus_if.rdata !== 32'h1) begin bad++; $display("FAIL par_rdata got=%0h exp=1", bus_if.rdata); end
        total++; if (bus_if.par_err !== 1'b1) begin bad++; $display("FAIL par_err_flip got=%0h exp=1", bus_if.par_err); end
        @(posedge clk);
        #1;
        total++; if (bus_if.par_err !== 1'b0) begin bad++; $display("FAIL par_err_pulse got=%0h exp=0", bus_if.par_err); end
        do_req(1'b1, 10'd3, 32'h0000_0001);
`endif
        do_req(1'b0, 10'd3, '0);
        total++; if (bus_if.rdata !== 32'h1) begin bad++; $display("FAIL rd3_rdata got=%0h exp=1", bus_if.rdata); end
        total++; if (bus_if.par_err !== 1'b0) begin bad++; $display("FAIL rd3_par_err got=%0h exp=0", bus_if.par_err); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_addr_err();
        test_reset_mid_clear();
        test_req_during_clear();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
